// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Two-port (fetch, load/store) arbiter in front of one single-port SRAM; data wins by default.
// Define MEM_ARB_STARVE_GUARD_EN to let a fetch that has lost STARVE_LIMIT times win once.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} state_e;

    state_e state_q, state_d;
    logic   starve;

    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starve = (starve_cnt_q == 4'(STARVE_LIMIT));

    // Counts consecutive cycles a pending fetch lost; saturates instead of wrapping.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || inst_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        inst_gnt   = 1'b0;
        data_gnt   = 1'b0;
        if (resetn) begin
            inst_gnt = inst_req & (~data_req | starve);
            data_gnt = data_req & ~inst_gnt;
        end
        sram_en    = inst_gnt | data_gnt;
        sram_we    = data_gnt ? data_we : 4'h0;
        sram_addr  = data_gnt ? data_addr : inst_addr;
        sram_wdata = data_gnt ? data_wdata : 32'h0;
        state_d    = StIdle;
        if (data_gnt) begin
            state_d = StOwnD;
        end else if (inst_gnt) begin
            state_d = StOwnI;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Gating with resetn drops a response whose grant preceded a reset.
    assign inst_rvalid = resetn && (state_q == StOwnI);
    assign data_rvalid = resetn && (state_q == StOwnD);
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for mem_port_arbiter: behavioural SRAM plus per-port response scoreboard.
module tb_mem_port_arbiter;

    localparam int unsigned StarveLimit = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    // Bit 32 set: compare rdata; clear: write completion, only rvalid matters.
    logic [32:0] exp_i[$];
    logic [32:0] exp_d[$];
    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT(StarveLimit)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_gnt   (inst_gnt),
        .inst_rvalid(inst_rvalid),
        .inst_rdata (inst_rdata),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_gnt   (data_gnt),
        .data_rvalid(data_rvalid),
        .data_rdata (data_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h1C00_0000) return 32'h0280_0421;
        return {a[15:0], ~a[15:0]};
    endfunction

    logic [31:0] mem [logic [29:0]];

    always @(posedge clk) begin : sram_model
        logic [31:0] w;
        if (sram_en) begin
            w = mem.exists(sram_addr[31:2]) ? mem[sram_addr[31:2]]
                                            : init_word({sram_addr[31:2], 2'b00});
            if (sram_we == 4'h0) begin
                sram_rdata <= w;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[sram_addr[31:2]] = w;
                sram_rdata <= 32'h0;
            end
        end
    end

    task automatic drive_idle();
        inst_req   = 1'b0;
        inst_addr  = 32'h0;
        data_req   = 1'b0;
        data_we    = 4'h0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
    endtask

    task automatic test_reset();
        drive_idle();
        resetn   = 1'b0;
        inst_req = 1'b1;
        data_req = 1'b1;
        data_we  = 4'hF;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({inst_gnt, data_gnt, sram_en, sram_we} !== 7'b0) begin
                failures++;
                $display("FAIL reset_outputs: got %b required 0",
                         {inst_gnt, data_gnt, sram_en, sram_we});
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({inst_rvalid, data_rvalid, inst_gnt, data_gnt, sram_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b required 0",
                     {inst_rvalid, data_rvalid, inst_gnt, data_gnt, sram_en});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_fetch();
        logic [32:0] e;
        for (int k = 0; k < 2; k++) begin
            drive_idle();
            inst_req  = (k == 0);
            inst_addr = 32'h1C00_0000;
            @(negedge clk);
            checks++;
            if (inst_rvalid !== (exp_i.size() != 0)) begin
                failures++;
                $display("FAIL fetch_rvalid: got %b required %b", inst_rvalid, exp_i.size() != 0);
                exp_i.delete();
            end else if (inst_rvalid) begin
                e = exp_i.pop_front();
                checks++;
                if (inst_rdata !== e[31:0]) begin
                    failures++;
                    $display("FAIL fetch_rdata: got %h required %h", inst_rdata, e[31:0]);
                end
            end
            checks++;
            if ({inst_gnt, data_gnt, sram_en, sram_we} !== {k == 0, 1'b0, k == 0, 4'h0}) begin
                failures++;
                $display("FAIL fetch_gnt k=%0d: got %b", k, {inst_gnt, data_gnt, sram_en, sram_we});
            end
            if (k == 0) begin
                checks++;
                if (sram_addr !== 32'h1C00_0000 || sram_wdata !== 32'h0) begin
                    failures++;
                    $display("FAIL fetch_sram: got addr %h wdata %h required 1c000000 0",
                             sram_addr, sram_wdata);
                end
                exp_i.push_back({1'b1, 32'h0280_0421});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_load();
        logic [32:0] e;
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            data_req   = (k < 2);
            data_we    = (k == 0) ? 4'hF : 4'h0;
            data_addr  = 32'h100;
            data_wdata = (k == 0) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            checks++;
            if (data_rvalid !== (exp_d.size() != 0)) begin
                failures++;
                $display("FAIL stld_rvalid k=%0d: got %b required %b", k, data_rvalid,
                         exp_d.size() != 0);
                exp_d.delete();
            end else if (data_rvalid) begin
                e = exp_d.pop_front();
                if (e[32]) begin
                    checks++;
                    if (data_rdata !== e[31:0]) begin
                        failures++;
                        $display("FAIL stld_rdata: got %h required %h", data_rdata, e[31:0]);
                    end
                end
            end
            checks++;
            if ({data_gnt, inst_gnt, sram_en, sram_we} !==
                {k < 2, 1'b0, k < 2, (k == 0) ? 4'hF : 4'h0}) begin
                failures++;
                $display("FAIL stld_cmd k=%0d: got %b", k, {data_gnt, inst_gnt, sram_en, sram_we});
            end
            if (k == 0) begin
                checks++;
                if (sram_addr !== 32'h100 || sram_wdata !== 32'hDEAD_BEEF) begin
                    failures++;
                    $display("FAIL stld_wr: got addr %h wdata %h required 100 deadbeef",
                             sram_addr, sram_wdata);
                end
                exp_d.push_back({1'b0, 32'h0});
            end else if (k == 1) begin
                exp_d.push_back({1'b1, 32'hDEAD_BEEF});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        logic [32:0] e;
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            inst_req  = (k < 2);
            inst_addr = 32'h1C00_0004;
            data_req  = (k == 0);
            data_addr = 32'h200;
            @(negedge clk);
            checks++;
            if ({inst_rvalid, data_rvalid} !== {exp_i.size() != 0, exp_d.size() != 0}) begin
                failures++;
                $display("FAIL cont_rvalid k=%0d: got %b%b required %b%b", k, inst_rvalid,
                         data_rvalid, exp_i.size() != 0, exp_d.size() != 0);
                exp_i.delete();
                exp_d.delete();
            end else if (inst_rvalid || data_rvalid) begin
                e = inst_rvalid ? exp_i.pop_front() : exp_d.pop_front();
                checks++;
                if ((inst_rvalid ? inst_rdata : data_rdata) !== e[31:0]) begin
                    failures++;
                    $display("FAIL cont_rdata k=%0d: got %h required %h", k,
                             inst_rvalid ? inst_rdata : data_rdata, e[31:0]);
                end
            end
            checks++;
            if ({data_gnt, inst_gnt} !== {k == 0, k == 1}) begin
                failures++;
                $display("FAIL cont_gnt k=%0d: got %b%b required %b%b", k, data_gnt, inst_gnt,
                         k == 0, k == 1);
            end
            if (k == 0) exp_d.push_back({1'b1, init_word(32'h200)});
            if (k == 1) exp_i.push_back({1'b1, init_word(32'h1C00_0004)});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_starvation();
        logic [32:0] e;
        logic        eig;
        logic        edg;
        for (int k = 0; k < 10; k++) begin
            drive_idle();
            inst_req  = (k < 9);
            inst_addr = 32'h1C00_0008;
            data_req  = (k < 8);
            data_addr = 32'h300;
            eig = (k == 8) || (Guard && (k == int'(StarveLimit)));
            edg = (k < 8) && !eig;
            @(negedge clk);
            checks++;
            if ({inst_rvalid, data_rvalid} !== {exp_i.size() != 0, exp_d.size() != 0}) begin
                failures++;
                $display("FAIL starve_rvalid k=%0d: got %b%b required %b%b", k, inst_rvalid,
                         data_rvalid, exp_i.size() != 0, exp_d.size() != 0);
                exp_i.delete();
                exp_d.delete();
            end else if (inst_rvalid || data_rvalid) begin
                e = inst_rvalid ? exp_i.pop_front() : exp_d.pop_front();
                checks++;
                if ((inst_rvalid ? inst_rdata : data_rdata) !== e[31:0]) begin
                    failures++;
                    $display("FAIL starve_rdata k=%0d: got %h required %h", k,
                             inst_rvalid ? inst_rdata : data_rdata, e[31:0]);
                end
            end
            checks++;
            if ({inst_gnt, data_gnt} !== {eig, edg}) begin
                failures++;
                $display("FAIL starve_gnt k=%0d: got %b%b required %b%b", k, inst_gnt, data_gnt,
                         eig, edg);
            end
            if (eig) exp_i.push_back({1'b1, init_word(32'h1C00_0008)});
            if (edg) exp_d.push_back({1'b1, init_word(32'h300)});
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midop();
        drive_idle();
        data_req  = 1'b1;
        data_addr = 32'h400;
        @(negedge clk);
        checks++;
        if (data_gnt !== 1'b1) begin
            failures++;
            $display("FAIL midop_gnt: got %b required 1", data_gnt);
        end
        @(posedge clk); #1;
        resetn   = 1'b0;
        inst_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_rvalid, inst_rvalid, inst_gnt, data_gnt, sram_en} !== 5'b0) begin
            failures++;
            $display("FAIL midop_in_reset: got %b required 0",
                     {data_rvalid, inst_rvalid, inst_gnt, data_gnt, sram_en});
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({data_rvalid, inst_rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL midop_after: got %b required 00", {data_rvalid, inst_rvalid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        int          n_gnt = 0;
        int          n_rv  = 0;
        for (int k = 0; k < 9; k++) begin
            drive_idle();
            inst_req  = (k < 8);
            inst_addr = 32'h1C00_0100 + 32'(4 * k);
            @(negedge clk);
            checks++;
            if (inst_rvalid !== (exp_i.size() != 0)) begin
                failures++;
                $display("FAIL stream_rvalid k=%0d: got %b required %b", k, inst_rvalid,
                         exp_i.size() != 0);
                exp_i.delete();
            end else if (inst_rvalid) begin
                n_rv++;
                e = exp_i.pop_front();
                checks++;
                if (inst_rdata !== e[31:0]) begin
                    failures++;
                    $display("FAIL stream_rdata k=%0d: got %h required %h", k, inst_rdata, e[31:0]);
                end
            end
            if (inst_gnt) n_gnt++;
            if (k < 8) exp_i.push_back({1'b1, init_word(32'h1C00_0100 + 32'(4 * k))});
            @(posedge clk); #1;
        end
        checks++;
        if (n_gnt != 8 || n_rv != 8) begin
            failures++;
            $display("FAIL stream_count: got gnt %0d rvalid %0d required 8 8", n_gnt, n_rv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        drive_idle();
        test_reset();
        test_single_fetch();
        test_store_load();
        test_contention();
        test_starvation();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive cycles a pending inst request may lose arbitration; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port inst_req, input, 1: fetch request; held with inst_addr stable until inst_gnt.
REQ-005 SHALL have port inst_addr, input, 32: fetch byte address.
REQ-006 SHALL have port inst_gnt, output, 1: fetch request accepted this cycle.
REQ-007 SHALL have port inst_rvalid, output, 1: inst_rdata valid this cycle.
REQ-008 SHALL have port inst_rdata, output, 32: fetch data.
REQ-009 SHALL have port data_req, input, 1: load/store request; held with data_we/data_addr/data_wdata stable until data_gnt.
REQ-010 SHALL have port data_we, input, 4: byte write enables; 4'h0 means read.
REQ-011 SHALL have port data_addr, input, 32: data byte address.
REQ-012 SHALL have port data_wdata, input, 32: store data.
REQ-013 SHALL have port data_gnt, output, 1: data request accepted this cycle.
REQ-014 SHALL have port data_rvalid, output, 1: data response (read data or write completion) this cycle.
REQ-015 SHALL have port data_rdata, output, 32: load data.
REQ-016 SHALL have ports sram_en (output, 1), sram_we (output, 4), sram_addr (output, 32), sram_wdata (output, 32): shared single-port SRAM command.
REQ-017 SHALL have port sram_rdata, input, 32: SRAM read data, valid one cycle after an enabled read.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt is combinational from req and arbitration state.
REQ-019 SHALL drive the SRAM in the grant cycle: sram_en=1, sram_addr/sram_we/sram_wdata from the winner (sram_we=0, sram_wdata=0 for inst); otherwise sram_en=0, sram_we=0.
REQ-020 SHALL assert the winner's rvalid exactly one cycle after its grant, for reads and writes alike.
REQ-021 SHALL drive inst_rdata and data_rdata directly from sram_rdata; values are meaningful only with the matching rvalid.
REQ-022 SHALL use owner FSM IDLE/OWN_I/OWN_D: grant to inst -> OWN_I, grant to data -> OWN_D, no grant -> IDLE; state selects which rvalid fires.
REQ-023 SHALL allow back-to-back grants: a new grant is legal in the same cycle as a previous response, giving one access per cycle.
REQ-024 SHALL give data priority over inst when both request, except as REQ-026 states.
REQ-025 SHALL hold a saturating counter of consecutive cycles with inst_req=1 and inst_gnt=0; counter clears on inst_gnt or inst_req=0.
REQ-026 SHALL grant inst over data when counter equals STARVE_LIMIT.
REQ-027 SHALL NOT raise gnt for a requester whose req is 0; no request -> all gnt 0, FSM to IDLE.

Reset
REQ-028 SHALL, with resetn=0 at a clock edge, set FSM to IDLE and counter to 0.
REQ-029 SHALL force inst_gnt, data_gnt, sram_en, sram_we to 0 while resetn=0; rvalid outputs are 0 in the cycle after reset is sampled.
REQ-030 SHALL discard an in-flight access when reset is asserted: no rvalid is issued for it.

Configuration
REQ-031 SHALL, with MEM_ARB_STARVE_GUARD_EN defined, implement REQ-025/026.
REQ-032 SHALL, without MEM_ARB_STARVE_GUARD_EN, omit the counter and use pure fixed data-over-inst priority; STARVE_LIMIT is ignored.

Verification
REQ-033 SHALL check single fetch: inst_req, addr 0x1C000000, SRAM returns 0x02800421 -> inst_gnt cycle 0, inst_rvalid with rdata 0x02800421 cycle 1.
REQ-034 SHALL check store then load: data_we=4'hF, addr 0x100, wdata 0xDEADBEEF, then read 0x100 -> sram_we 4'hF cycle 0, data_rvalid cycles 1 and 2, load rdata 0xDEADBEEF.
REQ-035 SHALL check contention: both req same cycle -> data_gnt=1, inst_gnt=0; inst granted the following cycle once data_req drops.
REQ-036 SHALL check starvation, guard enabled, STARVE_LIMIT=4: data_req held high with inst_req high -> inst_gnt in the 5th cycle; guard disabled -> inst_gnt never while data_req is high.
REQ-037 SHALL check reset mid-op: resetn low in the cycle after data_gnt -> no data_rvalid; all gnt/sram_en 0 during reset.
REQ-038 SHALL check streaming: 8 consecutive fetches with inst_req held high -> 8 grants and 8 rvalids in consecutive cycles.
